// File: rtl/alu_pipe.sv
// alu_pipe: single-cycle ALU with an optional iterative shift-add multiplier
// and a one-entry valid/ready result register.
// WIDTH must be a power of two in the range 8..64.
module alu_pipe #(
   parameter int WIDTH  = 32,
   parameter int MUL_EN = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       f,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             of,
   output logic             busy
);

   localparam int SHW = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_NOR  = 4'b0100;
   localparam logic [3:0] OP_SLTU = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;
   localparam logic [3:0] OP_MUL  = 4'b1100;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_t;

   state_t             state_reg;
   state_t             state_next;

   // Result register
   logic [WIDTH-1:0]   y_reg;
   logic               zero_reg;
   logic               of_reg;
   logic               out_valid_reg;

   // Multiplier datapath: prod_reg starts as {0, b} and accumulates the
   // partial products in its upper half while shifting b out of the bottom.
   logic [2*WIDTH-1:0] prod_reg;
   logic [WIDTH-1:0]   mcand_reg;
   logic [SHW-1:0]     cnt_reg;

   logic               accept;
   logic               is_mul_op;
   logic               start_mul;
   logic               mul_done;
   logic               load_res;

   logic [WIDTH:0]     step_sum;
   logic [2*WIDTH-1:0] prod_step;

   logic [SHW-1:0]     shamt;
   logic [WIDTH-1:0]   add_res;
   logic [WIDTH-1:0]   sub_res;
   logic [WIDTH-1:0]   alu_y;
   logic               alu_of;
   logic [WIDTH-1:0]   res_y;
   logic               res_of;

   // Handshake and control decode
   always_comb begin
      in_ready  = (state_reg == IDLE) && (!out_valid_reg || out_ready);
      accept    = in_valid && in_ready;
      is_mul_op = (MUL_EN != 0) && (f == OP_MUL);
      start_mul = accept && is_mul_op;
      mul_done  = (state_reg == MUL) && (cnt_reg == SHW'(WIDTH - 1));
      load_res  = (accept && !is_mul_op) || mul_done;
      busy      = (state_reg == MUL);
   end

   // Single-cycle ALU operations; undefined opcodes (and MUL when disabled) give y=0, of=0
   always_comb begin
      shamt   = b[SHW-1:0];
      add_res = a + b;
      sub_res = a - b;
      alu_y   = '0;
      alu_of  = 1'b0;
      case (f)
         OP_AND:  alu_y = a & b;
         OP_OR:   alu_y = a | b;
         OP_ADD: begin
            alu_y  = add_res;
            alu_of = (a[MSB] == b[MSB]) && (add_res[MSB] != a[MSB]);
         end
         OP_XOR:  alu_y = a ^ b;
         OP_NOR:  alu_y = ~(a | b);
         OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_SUB: begin
            alu_y  = sub_res;
            alu_of = (a[MSB] != b[MSB]) && (sub_res[MSB] != a[MSB]);
         end
         OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLL:  alu_y = a << shamt;
         OP_SRL:  alu_y = a >> shamt;
         OP_SRA:  alu_y = $unsigned($signed(a) >>> shamt);
         default: begin
            alu_y  = '0;
            alu_of = 1'b0;
         end
      endcase
   end

   // One shift-add multiply step: add the multiplicand when the current
   // multiplier bit is set, then shift the whole product right by one
   always_comb begin
      step_sum  = {1'b0, prod_reg[2*WIDTH-1:WIDTH]}
                + (prod_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
      prod_step = {step_sum, prod_reg[WIDTH-1:1]};
   end

   // Select what loads into the result register
   always_comb begin
      if (mul_done) begin
         res_y  = prod_step[WIDTH-1:0];
         res_of = |prod_step[2*WIDTH-1:WIDTH];
      end else begin
         res_y  = alu_y;
         res_of = alu_of;
      end
   end

   // FSM next-state: leave IDLE on an accepted multiply, return after the last step
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (start_mul) state_next = MUL;
         MUL:  if (mul_done)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Multiplier registers: load operands on accept, step once per MUL cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_reg  <= '0;
         mcand_reg <= '0;
         cnt_reg   <= '0;
      end else if (start_mul) begin
         prod_reg  <= {{WIDTH{1'b0}}, b};
         mcand_reg <= a;
         cnt_reg   <= '0;
      end else if (state_reg == MUL) begin
         prod_reg  <= prod_step;
         cnt_reg   <= cnt_reg + SHW'(1);
      end
   end

   // Result register: a new result wins over draining; otherwise hold until consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_reg         <= '0;
         zero_reg      <= 1'b1;
         of_reg        <= 1'b0;
         out_valid_reg <= 1'b0;
      end else if (load_res) begin
         y_reg         <= res_y;
         zero_reg      <= (res_y == '0);
         of_reg        <= res_of;
         out_valid_reg <= 1'b1;
      end else if (out_valid_reg && out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign y         = y_reg;
   assign zero      = zero_reg;
   assign of        = of_reg;
   assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vector table, hand-written handshake/reset sequences
// and randomized traffic checked against an arithmetic reference model.
module tb_alu_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] a, b, y;
   logic [3:0]  f;
   logic        zero, of, busy;

   // Second instance: narrow datapath with the multiplier disabled
   logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready;
   logic [7:0]  n_a, n_b, n_y;
   logic [3:0]  n_f;
   logic        n_zero, n_of, n_busy;

   int checks   = 0;
   int failures = 0;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   alu_pipe #(.WIDTH(32), .MUL_EN(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .f(f), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .zero(zero), .of(of), .busy(busy)
   );

   alu_pipe #(.WIDTH(8), .MUL_EN(0)) dut_nomul (
      .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
      .a(n_a), .b(n_b), .f(n_f), .out_valid(n_out_valid), .out_ready(n_out_ready),
      .y(n_y), .zero(n_zero), .of(n_of), .busy(n_busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] va;
      logic [31:0] vb;
      logic [3:0]  vf;
      logic [31:0] ey;
      logic        eof;
      logic [7:0]  elat;
   } vec_t;

   vec_t tv [18];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // Reference model from the opcode rules using wide signed/unsigned arithmetic
   function automatic void ref_model(input logic [31:0] ra, input logic [31:0] rb,
                                     input logic [3:0] rf,
                                     output logic [31:0] ry, output logic rof);
      longint      sa, sb, s;
      logic [63:0] p;
      int          sh;
      sa  = $signed(ra);
      sb  = $signed(rb);
      sh  = int'(rb[4:0]);
      ry  = 32'h0;
      rof = 1'b0;
      case (rf)
         4'd0:  ry = ra & rb;
         4'd1:  ry = ra | rb;
         4'd2: begin s = sa + sb; ry = s[31:0]; rof = (s > SMAX) || (s < SMIN); end
         4'd3:  ry = ra ^ rb;
         4'd4:  ry = ~(ra | rb);
         4'd5:  ry = (ra < rb) ? 32'd1 : 32'd0;
         4'd6: begin s = sa - sb; ry = s[31:0]; rof = (s > SMAX) || (s < SMIN); end
         4'd7:  ry = (sa < sb) ? 32'd1 : 32'd0;
         4'd8:  ry = ra << sh;
         4'd9:  ry = ra >> sh;
         4'd10: begin s = sa >>> sh; ry = s[31:0]; end
         4'd12: begin p = 64'(ra) * 64'(rb); ry = p[31:0]; rof = (p[63:32] != 32'h0); end
         default: begin ry = 32'h0; rof = 1'b0; end
      endcase
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'h7FFFFFFF;
         default: return $urandom;
      endcase
   endfunction

   // Issue one op, wait for its result; lat counts edges after the accept edge
   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic [3:0] tf,
                         output logic [31:0] ry, output logic rof, output logic rz,
                         output int lat, output logic bad_busy);
      int guard;
      in_valid = 1'b1; a = ta; b = tb_v; f = tf; out_ready = 1'b1;
      #1;
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(posedge clk); #1; guard++;
      end
      if (guard >= 100) timeout_fail("accept_wait");
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      bad_busy = 1'b0;
      while (!out_valid && lat < 200) begin
         if (!busy || in_ready) bad_busy = 1'b1;
         @(posedge clk); #1; lat++;
      end
      if (lat >= 200) timeout_fail("result_wait");
      ry = y; rof = of; rz = zero;
   endtask

   initial begin
      logic [31:0] ry, ey;
      logic        rof, rz, eof, bad;
      int          lat;
      logic [31:0] q_y[$];
      logic        q_of[$];
      int          issued, got;
      logic        prev_hold;
      logic [31:0] prev_y;
      logic [31:0] b2b_a[4], b2b_b[4], b2b_y[4];
      logic [3:0]  b2b_f[4];
      localparam int NRAND = 200;

      tv[0]  = '{32'h7FFFFFFF, 32'h00000001, 4'd2,  32'h80000000, 1'b1, 8'd0};
      tv[1]  = '{32'h00000005, 32'h00000005, 4'd6,  32'h00000000, 1'b0, 8'd0};
      tv[2]  = '{32'hFFFFFFFF, 32'h00000001, 4'd7,  32'h00000001, 1'b0, 8'd0};
      tv[3]  = '{32'hFFFFFFFF, 32'h00000001, 4'd5,  32'h00000000, 1'b0, 8'd0};
      tv[4]  = '{32'h80000000, 32'h00000024, 4'd10, 32'hF8000000, 1'b0, 8'd0};
      tv[5]  = '{32'h00000001, 32'h0000001F, 4'd8,  32'h80000000, 1'b0, 8'd0};
      tv[6]  = '{32'h00010000, 32'h00010000, 4'd12, 32'h00000000, 1'b1, 8'd32};
      tv[7]  = '{32'hF0F0F0F0, 32'hFF00FF00, 4'd0,  32'hF000F000, 1'b0, 8'd0};
      tv[8]  = '{32'h00000F00, 32'h000000F0, 4'd1,  32'h00000FF0, 1'b0, 8'd0};
      tv[9]  = '{32'hFFFF0000, 32'hFF00FF00, 4'd3,  32'h00FFFF00, 1'b0, 8'd0};
      tv[10] = '{32'h00000000, 32'h00000000, 4'd4,  32'hFFFFFFFF, 1'b0, 8'd0};
      tv[11] = '{32'h80000000, 32'h0000003F, 4'd9,  32'h00000001, 1'b0, 8'd0};
      tv[12] = '{32'h80000000, 32'h00000001, 4'd6,  32'h7FFFFFFF, 1'b1, 8'd0};
      tv[13] = '{32'h00000003, 32'h00000005, 4'd12, 32'h0000000F, 1'b0, 8'd32};
      tv[14] = '{32'hFFFFFFFF, 32'h00000001, 4'd11, 32'h00000000, 1'b0, 8'd0};
      tv[15] = '{32'h12345678, 32'h9ABCDEF0, 4'd15, 32'h00000000, 1'b0, 8'd0};
      tv[16] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'd12, 32'h00000001, 1'b1, 8'd32};
      tv[17] = '{32'hFFFFFFFF, 32'h00000001, 4'd2,  32'h00000000, 1'b0, 8'd0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; f = '0;
      n_in_valid = 1'b0; n_out_ready = 1'b1; n_a = '0; n_b = '0; n_f = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_y", y, 0);
      check("rst_zero", zero, 1);
      check("rst_of", of, 0);
      check("rst_in_ready", in_ready, 1);

      // First acceptance on the first edge after release
      rst_n = 1'b1; in_valid = 1'b1; a = 32'd2; b = 32'd3; f = 4'd2; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("first_accept_valid", out_valid, 1);
      check("first_accept_y", y, 32'd5);
      @(posedge clk); #1;
      check("drain_valid", out_valid, 0);

      // Directed vector table
      for (int i = 0; i < 18; i++) begin
         run_op(tv[i].va, tv[i].vb, tv[i].vf, ry, rof, rz, lat, bad);
         check($sformatf("vec%0d_y", i), ry, tv[i].ey);
         check($sformatf("vec%0d_of", i), rof, tv[i].eof);
         check($sformatf("vec%0d_zero", i), rz, (tv[i].ey == 32'h0));
         check($sformatf("vec%0d_latency", i), lat, tv[i].elat);
         if (tv[i].elat != 0) begin
            check($sformatf("vec%0d_busy_during_mul", i), bad, 0);
            check($sformatf("vec%0d_busy_after_mul", i), busy, 0);
         end
         $display("vec %0d: f=%0d a=%08h b=%08h y=%08h of=%0d lat=%0d", i, tv[i].vf, tv[i].va, tv[i].vb, ry, rof, lat);
      end

      // Back-to-back single-cycle ops: one result per cycle
      b2b_a = '{32'd1, 32'd10, 32'hF, 32'd1};
      b2b_b = '{32'd2, 32'd3, 32'h3, 32'd4};
      b2b_f = '{4'd2, 4'd6, 4'd3, 4'd8};
      b2b_y = '{32'd3, 32'd7, 32'hC, 32'h10};
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; a = b2b_a[i]; b = b2b_b[i]; f = b2b_f[i];
         #1;
         check($sformatf("b2b%0d_in_ready", i), in_ready, 1);
         @(posedge clk); #1;
         check($sformatf("b2b%0d_valid", i), out_valid, 1);
         check($sformatf("b2b%0d_y", i), y, b2b_y[i]);
         $display("b2b %0d: y=%08h", i, y);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;

      // Backpressure: AND result held for 5 cycles, then replaced on the draining edge
      out_ready = 1'b0; in_valid = 1'b1; a = 32'h0000F0F0; b = 32'h0000FF00; f = 4'd0;
      @(posedge clk); #1;
      a = 32'd2; b = 32'd3; f = 4'd2;
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("hold%0d_y", k), y, 32'h0000F000);
         check($sformatf("hold%0d_valid", k), out_valid, 1);
         check($sformatf("hold%0d_in_ready", k), in_ready, 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      check("release_in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("replace_valid", out_valid, 1);
      check("replace_y", y, 32'd5);
      $display("backpressure: replaced y=%08h", y);
      @(posedge clk); #1;
      check("replace_drained", out_valid, 0);

      // Reset in the middle of a multiply
      in_valid = 1'b1; a = 32'd7; b = 32'd9; f = 4'd12;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("abort_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      check("abort_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_y", y, 0);
      check("abort_zero", zero, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bad = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid || busy) bad = 1'b1;
      end
      check("abort_no_result", bad, 0);
      run_op(32'd2, 32'd3, 4'd2, ry, rof, rz, lat, bad);
      check("abort_next_add_y", ry, 32'd5);
      check("abort_next_add_lat", lat, 0);
      $display("abort: next add y=%08h", ry);

      // Multiply-disabled instance: opcode 1100 is undefined and single-cycle
      n_in_valid = 1'b1; n_a = 8'hFF; n_b = 8'h02; n_f = 4'd12;
      #1;
      check("nomul_in_ready", n_in_ready, 1);
      @(posedge clk); #1;
      n_a = 8'h7F; n_b = 8'h01; n_f = 4'd2;
      check("nomul_valid", n_out_valid, 1);
      check("nomul_y", n_y, 0);
      check("nomul_of", n_of, 0);
      check("nomul_zero", n_zero, 1);
      check("nomul_busy", n_busy, 0);
      @(posedge clk); #1;
      n_in_valid = 1'b0;
      check("nomul_add_y", n_y, 8'h80);
      check("nomul_add_of", n_of, 1);
      $display("nomul: add y=%02h of=%0d", n_y, n_of);

      // Randomized traffic with random backpressure against the reference model
      out_ready = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      issued = 0; got = 0; prev_hold = 1'b0; prev_y = '0;
      for (int cyc = 0; cyc < 20000 && (issued < NRAND || q_y.size() != 0); cyc++) begin
         in_valid  = (issued < NRAND) && ($urandom_range(0, 3) != 0);
         a = rand_operand(); b = rand_operand(); f = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (prev_hold) begin
            check("rand_hold_y", y, prev_y);
            check("rand_hold_valid", out_valid, 1);
         end
         check("rand_in_ready_rule", in_ready, !busy && (!out_valid || out_ready));
         if (out_valid && out_ready) begin
            if (q_y.size() == 0) begin
               timeout_fail("rand_unexpected_result");
            end else begin
               ey  = q_y.pop_front();
               eof = q_of.pop_front();
               check("rand_y", y, ey);
               check("rand_of", of, eof);
               check("rand_zero", zero, (ey == 32'h0));
               $display("rand %0d: y=%08h exp=%08h of=%0d", got, y, ey, of);
               got++;
            end
         end
         if (in_valid && in_ready) begin
            ref_model(a, b, f, ey, eof);
            q_y.push_back(ey);
            q_of.push_back(eof);
            issued++;
         end
         prev_hold = out_valid && !out_ready;
         prev_y    = y;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("rand_result_count", got, NRAND);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
